wb_spram32: RTL and testbench
=============================

# wb_spram32

Single-port 32-bit synchronous RAM with a Wishbone B4 pipelined slave port. It is the program/data memory behind the shared-bus Wishbone interconnect in the CPU subsystem, serving both instruction fetch and data masters. Memory contents are preloadable from a `$readmemh` vmem file through a hierarchical reference to the array `mem`.

## Interface

- `SIZE`, default `'h10000`: memory size in bytes; a power of two, minimum 8. Depth is `SIZE/4` words.
- Connection is a single `wb_if` slave modport named `wb`. Signals as seen by the block:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cyc`  in  1  bus cycle active.
- `stb`  in  1  request strobe.
- `we`  in  1  1 = write, 0 = read.
- `adr`  in  32  byte address.
- `sel`  in  4  byte enables; `sel[i]` covers `dat[8i+7:8i]`.
- `dat_i`  in  32  write data (`wb.dat_m2s`).
- `dat_o`  out  32  read data (`wb.dat_s2m`).
- `ack`  out  1  request completed.
- `err`  out  1  request rejected.
- `stall`  out  1  hardwired 0.

## Operation

- Storage: `logic [31:0] mem [SIZE/4]`, indexed by `adr[$clog2(SIZE)-1:2]`. `adr[1:0]` is ignored.
- `mem` is never reset or initialised by RTL. The bench preloads it with `$readmemh`, one 32-bit word per vmem entry, word index 0 at byte address 0.
- Request accepted in a cycle where `cyc & stb & ~stall`. Because `stall` is 0, every such cycle is accepted.
- Write: for each `i` with `sel[i]=1`, `mem[idx][8i+:8] <= dat_i[8i+:8]`. Lanes with `sel[i]=0` are unchanged. `sel=0` completes with `ack` and writes nothing.
- Read: `dat_o <= mem[idx]` (full word, regardless of `sel`).
- `dat_o` updates only on accepted reads and holds its value otherwise.
- Exactly one `ack` (or `err`) per accepted request, in order. Back-to-back requests produce back-to-back acks.
- `cyc` deasserted in the cycle after acceptance: the response is suppressed (`ack=err=0`). A write performed at the accepting edge is not undone.
- No state machine. The response pipeline is a single registered stage: `ack_q`, `err_q`.

## Timing

- Latency: `ack`/`err` and `dat_o` are valid exactly 1 cycle after the accepting edge.
- Write takes effect at the accepting edge. A read accepted the next cycle returns the new data.
- Read and write to the same word in consecutive cycles is ordered by issue.
- Reset values: `ack=0`, `err=0`, `stall=0`, `dat_o=0`.
- `rst` has priority over a simultaneous request. A request in the reset cycle is neither written nor acked.
- Reset mid-operation: a pending ack is dropped, so `ack=0` in the cycle after `rst` is sampled.
- `ack` and `err` are never asserted together.

## Configuration

- `WB_SPRAM32_BOUNDS_ERR_EN` defined:
  - An accepted request with `adr >= SIZE` responds with `err=1`, `ack=0` after 1 cycle.
  - No write occurs and `dat_o` holds.
- Macro not defined:
  - Upper address bits are ignored and the address wraps modulo `SIZE`.
  - `err` is tied to 0.

## Structure

- Shared package `wb_pkg`:
  - `ADR_W=32`, `DAT_W=32`, `SEL_W=DAT_W/8`.
  - Typedefs `wb_adr_t`, `wb_dat_t`, `wb_sel_t`.
- No sub-module. `mem` stays in the top module so hierarchical preload (`<inst>.mem`) works.
- Byte-lane writes use a generate loop over `SEL_W`.

## Test plan

- Preload: `mem[0]=32'h00000093`, `mem[1]=32'h11223344`. Read `adr=0x4`, `sel=0xF` -> `ack=1` after 1 cycle, `dat_o=32'h11223344`.
- Write `0xDEADBEEF`, `sel=0xF`, to `0x100`, then read `0x100` in the next cycle -> `dat_o=0xDEADBEEF` with ack on consecutive cycles.
- Byte write:
  - `mem` at `0x4` = `0x11223344`; write `dat_i=0x0000AB00`, `sel=0x2` -> read returns `0x1122AB44`.
  - `sel=0x0` write -> `ack=1`, word unchanged.
- Pipelined reads of `0x0`, `0x4`, `0x8` on 3 consecutive cycles, `cyc` held -> 3 consecutive acks, in-order data, `stall` constantly 0.
- Reset:
  - Assert `rst` in the cycle after a read is accepted -> `ack=0`, `dat_o=0` next cycle.
  - Request during `rst` -> no write, no ack.
- Address `0x10000` with `SIZE='h10000`:
  - With macro -> `err=1`, `ack=0`, memory unchanged.
  - Without macro -> aliases `0x0`; a write there modifies `mem[0]`.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths and typedefs for the CPU subsystem interconnect.
package wb_pkg;

   localparam int ADR_W = 32;
   localparam int DAT_W = 32;
   localparam int SEL_W = DAT_W / 8;

   typedef logic [ADR_W-1:0] wb_adr_t;
   typedef logic [DAT_W-1:0] wb_dat_t;
   typedef logic [SEL_W-1:0] wb_sel_t;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle; clock and reset travel with the bus.
interface wb_if;
   import wb_pkg::*;

   logic    clk;
   logic    rst;
   logic    cyc;
   logic    stb;
   logic    we;
   wb_adr_t adr;
   wb_sel_t sel;
   wb_dat_t dat_m2s;
   wb_dat_t dat_s2m;
   logic    ack;
   logic    err;
   logic    stall;

   modport master (
      input  clk, rst, dat_s2m, ack, err, stall,
      output cyc, stb, we, adr, sel, dat_m2s
   );

   modport slave (
      input  clk, rst, cyc, stb, we, adr, sel, dat_m2s,
      output dat_s2m, ack, err, stall
   );

endinterface

// File: rtl/wb_spram32.sv
// Single-port 32-bit RAM behind a Wishbone B4 pipelined slave, one-cycle response.
// Define WB_SPRAM32_BOUNDS_ERR_EN to answer out-of-range addresses with err instead of wrapping.
module wb_spram32
   import wb_pkg::*;
#(
   parameter int unsigned SIZE = 'h10000
)(
   wb_if.slave wb
);

   localparam int AW = $clog2(SIZE);

   // Left without reset or init so a testbench can preload it hierarchically.
   wb_dat_t mem [SIZE/4];

   logic [AW-3:0] w_idx;
   logic          w_accept;
   logic          w_oob;
   logic          w_wrEn;
   logic          w_rdEn;
   logic          w_unusedAdr;
   wb_dat_t       w_laneMask;

   logic          r_ack;
   logic          r_err;
   wb_dat_t       r_dat;

   assign w_idx    = wb.adr[AW-1:2];
   assign w_accept = wb.cyc & wb.stb & ~wb.stall;

`ifdef WB_SPRAM32_BOUNDS_ERR_EN
   assign w_oob       = |wb.adr[ADR_W-1:AW];
   assign w_unusedAdr = ^wb.adr[1:0];
`else
   assign w_oob       = 1'b0;
   assign w_unusedAdr = ^{wb.adr[ADR_W-1:AW], wb.adr[1:0]};
`endif

   assign w_wrEn = w_accept & wb.we & ~w_oob & ~wb.rst;
   assign w_rdEn = w_accept & ~wb.we & ~w_oob;

   for (genvar i = 0; i < SEL_W; i++) begin : g_lane
      assign w_laneMask[8*i +: 8] = {8{wb.sel[i]}};
   end

   // Byte-lane merge: unselected lanes keep their stored value.
   always_ff @(posedge wb.clk) begin
      if (w_wrEn) begin
         mem[w_idx] <= (mem[w_idx] & ~w_laneMask) | (wb.dat_m2s & w_laneMask);
      end
   end

   always_ff @(posedge wb.clk) begin
      if (wb.rst) begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_accept & ~w_oob;
         r_err <= w_accept & w_oob;
         if (w_rdEn) begin
            r_dat <= mem[w_idx];
         end
      end
   end

   // A master that dropped cyc has abandoned the cycle, so its response is swallowed.
   assign wb.ack     = r_ack & wb.cyc;
`ifdef WB_SPRAM32_BOUNDS_ERR_EN
   assign wb.err     = r_err & wb.cyc;
`else
   assign wb.err     = 1'b0;
`endif
   assign wb.stall   = 1'b0;
   assign wb.dat_s2m = r_dat;

endmodule

// File: tb/tb_wb_spram32.sv
// Directed self-checking bench for wb_spram32; honours WB_SPRAM32_BOUNDS_ERR_EN.
module tb_wb_spram32;
   import wb_pkg::*;

   int compared   = 0;
   int mismatched = 0;

   wb_if bus ();

   wb_spram32 #(.SIZE('h10000)) dut (
      .wb (bus.slave)
   );

   always #5 bus.clk = ~bus.clk;

   task automatic driveReq(input logic iWe, input wb_adr_t iAdr, input wb_sel_t iSel, input wb_dat_t iDat);
      bus.cyc     = 1'b1;
      bus.stb     = 1'b1;
      bus.we      = iWe;
      bus.adr     = iAdr;
      bus.sel     = iSel;
      bus.dat_m2s = iDat;
   endtask

   // Request is accepted at the next rising edge; returns at the following falling edge where its response is visible.
   task automatic applyStimulus(input logic iWe, input wb_adr_t iAdr, input wb_sel_t iSel, input wb_dat_t iDat);
      driveReq(iWe, iAdr, iSel, iDat);
      @(negedge bus.clk);
   endtask

   task automatic applyIdle();
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      @(negedge bus.clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      bus.clk     = 1'b0;
      bus.rst     = 1'b1;
      bus.cyc     = 1'b0;
      bus.stb     = 1'b0;
      bus.we      = 1'b0;
      bus.adr     = '0;
      bus.sel     = '0;
      bus.dat_m2s = '0;
      dut.mem[0] = 32'h00000093;
      dut.mem[1] = 32'h11223344;
      dut.mem[2] = 32'h55667788;

      @(negedge bus.clk);
      @(negedge bus.clk);
      checkOutput("reset_ack",   {31'd0, bus.ack},   32'd0);
      checkOutput("reset_err",   {31'd0, bus.err},   32'd0);
      checkOutput("reset_stall", {31'd0, bus.stall}, 32'd0);
      checkOutput("reset_dat",   bus.dat_s2m,        32'h0);
      bus.rst = 1'b0;
      @(negedge bus.clk);

      // Preloaded word read.
      applyStimulus(1'b0, 32'h4, 4'hF, 32'h0);
      checkOutput("rd4_ack", {31'd0, bus.ack}, 32'd1);
      checkOutput("rd4_dat", bus.dat_s2m,      32'h11223344);
      applyIdle();
      checkOutput("idle_ack",     {31'd0, bus.ack}, 32'd0);
      checkOutput("idle_datHold", bus.dat_s2m,      32'h11223344);

      // Write then read-back on the very next cycle.
      applyStimulus(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
      checkOutput("wr100_ack", {31'd0, bus.ack}, 32'd1);
      applyStimulus(1'b0, 32'h100, 4'hF, 32'h0);
      checkOutput("rd100_ack", {31'd0, bus.ack}, 32'd1);
      checkOutput("rd100_dat", bus.dat_s2m,      32'hDEADBEEF);
      applyIdle();

      // Byte-lane write and the empty-select write.
      applyStimulus(1'b1, 32'h4, 4'h2, 32'h0000AB00);
      checkOutput("wrByte_ack", {31'd0, bus.ack}, 32'd1);
      applyStimulus(1'b0, 32'h4, 4'hF, 32'h0);
      checkOutput("rdByte_dat", bus.dat_s2m, 32'h1122AB44);
      applyStimulus(1'b1, 32'h4, 4'h0, 32'hFFFFFFFF);
      checkOutput("wrSel0_ack", {31'd0, bus.ack}, 32'd1);
      applyStimulus(1'b0, 32'h4, 4'hF, 32'h0);
      checkOutput("rdSel0_dat", bus.dat_s2m, 32'h1122AB44);
      applyIdle();

      // Three pipelined reads with cyc held.
      applyStimulus(1'b0, 32'h0, 4'hF, 32'h0);
      checkOutput("pipe0_ack",   {31'd0, bus.ack},   32'd1);
      checkOutput("pipe0_dat",   bus.dat_s2m,        32'h00000093);
      checkOutput("pipe0_stall", {31'd0, bus.stall}, 32'd0);
      applyStimulus(1'b0, 32'h4, 4'hF, 32'h0);
      checkOutput("pipe1_ack",   {31'd0, bus.ack},   32'd1);
      checkOutput("pipe1_dat",   bus.dat_s2m,        32'h1122AB44);
      checkOutput("pipe1_stall", {31'd0, bus.stall}, 32'd0);
      applyStimulus(1'b0, 32'h8, 4'hF, 32'h0);
      checkOutput("pipe2_ack",   {31'd0, bus.ack},   32'd1);
      checkOutput("pipe2_dat",   bus.dat_s2m,        32'h55667788);
      checkOutput("pipe2_stall", {31'd0, bus.stall}, 32'd0);
      applyIdle();

      // Dropping cyc right after acceptance swallows the ack but keeps the write.
      driveReq(1'b1, 32'h200, 4'hF, 32'hA5A5A5A5);
      @(posedge bus.clk);
      #1;
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      @(negedge bus.clk);
      checkOutput("cycDrop_ack", {31'd0, bus.ack}, 32'd0);
      applyStimulus(1'b0, 32'h200, 4'hF, 32'h0);
      checkOutput("cycDrop_dat", bus.dat_s2m, 32'hA5A5A5A5);
      applyIdle();

      // Reset right after an accepted read, with a write held during reset.
      driveReq(1'b0, 32'h100, 4'hF, 32'h0);
      @(posedge bus.clk);
      #1;
      bus.rst = 1'b1;
      bus.stb = 1'b0;
      @(negedge bus.clk);
      checkOutput("preRst_ack", {31'd0, bus.ack}, 32'd1);
      checkOutput("preRst_dat", bus.dat_s2m,      32'hDEADBEEF);
      driveReq(1'b1, 32'h100, 4'hF, 32'h12345678);
      @(negedge bus.clk);
      checkOutput("midRst_ack", {31'd0, bus.ack}, 32'd0);
      checkOutput("midRst_dat", bus.dat_s2m,      32'h0);
      bus.rst = 1'b0;
      applyIdle();
      checkOutput("postRst_ack", {31'd0, bus.ack}, 32'd0);
      applyStimulus(1'b0, 32'h100, 4'hF, 32'h0);
      checkOutput("rstNoWr_dat", bus.dat_s2m, 32'hDEADBEEF);
      applyIdle();

      // Address one past the end of the array.
      applyStimulus(1'b1, 32'h10000, 4'hF, 32'hCAFEF00D);
`ifdef WB_SPRAM32_BOUNDS_ERR_EN
      checkOutput("oobWr_err", {31'd0, bus.err}, 32'd1);
      checkOutput("oobWr_ack", {31'd0, bus.ack}, 32'd0);
      applyStimulus(1'b0, 32'h0, 4'hF, 32'h0);
      checkOutput("oobMem0_dat", bus.dat_s2m, 32'h00000093);
      applyStimulus(1'b0, 32'h10000, 4'hF, 32'h0);
      checkOutput("oobRd_err",     {31'd0, bus.err}, 32'd1);
      checkOutput("oobRd_datHold", bus.dat_s2m,      32'h00000093);
`else
      checkOutput("wrapWr_ack", {31'd0, bus.ack}, 32'd1);
      checkOutput("wrapWr_err", {31'd0, bus.err}, 32'd0);
      applyStimulus(1'b0, 32'h0, 4'hF, 32'h0);
      checkOutput("wrapMem0_dat", bus.dat_s2m, 32'hCAFEF00D);
`endif
      applyIdle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
